// File: rtl/cavlc_total_zeros_decoder.sv
// Bit-serial CAVLC total_zeros decoder for 4x4 luma blocks.
// Shifts in one bitstream bit per accepted beat, matches the growing code
// against the total_zeros table row selected by TotalCoeff, and reports the
// decoded value together with the number of bits consumed.
module cavlc_total_zeros_decoder #(
    parameter int MAX_LEN = 9,
    parameter int TZ_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TZ_W-1:0] total_coeff,
    input  logic            bit_in,
    input  logic            bit_valid,
    output logic            bit_ready,
    output logic            busy,
    output logic            tz_valid,
    output logic [TZ_W-1:0] tz_value,
    output logic [TZ_W-1:0] tz_len,
    output logic            tz_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]              state;
    logic [TZ_W-1:0]         tc_reg;
    logic [TZ_W-1:0]         cnt;
    logic [MAX_LEN-1:0]      code;
    logic [MAX_LEN-1:0]      next_code;
    logic [TZ_W-1:0]         next_len;
    logic [TZ_W-1:0]         row_max;
    logic [TZ_W+MAX_LEN-1:0] key;
    logic [TZ_W:0]           match;
    logic                    miss_end;

    // Handshake and status flags are plain decodes of the state register.
    assign bit_ready = (state == SHIFT);
    assign busy      = (state != IDLE);
    assign tz_valid  = (state == DONE);

    // The candidate codeword includes the bit currently on offer, so a hit is
    // recognised in the same cycle the final bit is transferred.
    assign next_code = {code[MAX_LEN-2:0], bit_in};
    assign next_len  = cnt + TZ_W'(1);
    assign key       = {next_len, next_code};
    assign miss_end  = (next_len == TZ_W'(MAX_LEN)) || (next_len == row_max);

    // Longest codeword in each TotalCoeff row; reaching it without a hit is an error.
    always_comb begin
        row_max = TZ_W'(1);
        case (tc_reg)
            4'd1:                      row_max = 4'd9;
            4'd2, 4'd3:                row_max = 4'd6;
            4'd4, 4'd5:                row_max = 4'd5;
            4'd6, 4'd7, 4'd8, 4'd9:    row_max = 4'd6;
            4'd10:                     row_max = 4'd5;
            4'd11, 4'd12:              row_max = 4'd4;
            4'd13:                     row_max = 4'd3;
            4'd14:                     row_max = 4'd2;
            default:                   row_max = 4'd1;
        endcase
    end

    // Exact (length, right-aligned pattern) lookup; match = {hit, total_zeros}.
    always_comb begin
        match = '0;
        case (tc_reg)
            4'd1: case (key)
                {4'd1, 9'b1}:         match = {1'b1, 4'd0};   {4'd3, 9'b011}:       match = {1'b1, 4'd1};
                {4'd3, 9'b010}:       match = {1'b1, 4'd2};   {4'd4, 9'b0011}:      match = {1'b1, 4'd3};
                {4'd4, 9'b0010}:      match = {1'b1, 4'd4};   {4'd5, 9'b00011}:     match = {1'b1, 4'd5};
                {4'd5, 9'b00010}:     match = {1'b1, 4'd6};   {4'd6, 9'b000011}:    match = {1'b1, 4'd7};
                {4'd6, 9'b000010}:    match = {1'b1, 4'd8};   {4'd7, 9'b0000011}:   match = {1'b1, 4'd9};
                {4'd7, 9'b0000010}:   match = {1'b1, 4'd10};  {4'd8, 9'b00000011}:  match = {1'b1, 4'd11};
                {4'd8, 9'b00000010}:  match = {1'b1, 4'd12};  {4'd9, 9'b000000011}: match = {1'b1, 4'd13};
                {4'd9, 9'b000000010}: match = {1'b1, 4'd14};  {4'd9, 9'b000000001}: match = {1'b1, 4'd15};
                default:              match = '0;
            endcase
            4'd2: case (key)
                {4'd3, 9'b111}:       match = {1'b1, 4'd0};   {4'd3, 9'b110}:       match = {1'b1, 4'd1};
                {4'd3, 9'b101}:       match = {1'b1, 4'd2};   {4'd3, 9'b100}:       match = {1'b1, 4'd3};
                {4'd3, 9'b011}:       match = {1'b1, 4'd4};   {4'd4, 9'b0101}:      match = {1'b1, 4'd5};
                {4'd4, 9'b0100}:      match = {1'b1, 4'd6};   {4'd4, 9'b0011}:      match = {1'b1, 4'd7};
                {4'd4, 9'b0010}:      match = {1'b1, 4'd8};   {4'd5, 9'b00011}:     match = {1'b1, 4'd9};
                {4'd5, 9'b00010}:     match = {1'b1, 4'd10};  {4'd6, 9'b000011}:    match = {1'b1, 4'd11};
                {4'd6, 9'b000010}:    match = {1'b1, 4'd12};  {4'd6, 9'b000001}:    match = {1'b1, 4'd13};
                {4'd6, 9'b000000}:    match = {1'b1, 4'd14};
                default:              match = '0;
            endcase
            4'd3: case (key)
                {4'd4, 9'b0101}:      match = {1'b1, 4'd0};   {4'd3, 9'b111}:       match = {1'b1, 4'd1};
                {4'd3, 9'b110}:       match = {1'b1, 4'd2};   {4'd3, 9'b101}:       match = {1'b1, 4'd3};
                {4'd4, 9'b0100}:      match = {1'b1, 4'd4};   {4'd4, 9'b0011}:      match = {1'b1, 4'd5};
                {4'd3, 9'b100}:       match = {1'b1, 4'd6};   {4'd3, 9'b011}:       match = {1'b1, 4'd7};
                {4'd4, 9'b0010}:      match = {1'b1, 4'd8};   {4'd5, 9'b00011}:     match = {1'b1, 4'd9};
                {4'd5, 9'b00010}:     match = {1'b1, 4'd10};  {4'd6, 9'b000001}:    match = {1'b1, 4'd11};
                {4'd5, 9'b00001}:     match = {1'b1, 4'd12};  {4'd6, 9'b000000}:    match = {1'b1, 4'd13};
                default:              match = '0;
            endcase
            4'd4: case (key)
                {4'd5, 9'b00011}:     match = {1'b1, 4'd0};   {4'd3, 9'b111}:       match = {1'b1, 4'd1};
                {4'd4, 9'b0101}:      match = {1'b1, 4'd2};   {4'd4, 9'b0100}:      match = {1'b1, 4'd3};
                {4'd3, 9'b110}:       match = {1'b1, 4'd4};   {4'd3, 9'b101}:       match = {1'b1, 4'd5};
                {4'd3, 9'b100}:       match = {1'b1, 4'd6};   {4'd4, 9'b0011}:      match = {1'b1, 4'd7};
                {4'd3, 9'b011}:       match = {1'b1, 4'd8};   {4'd4, 9'b0010}:      match = {1'b1, 4'd9};
                {4'd5, 9'b00010}:     match = {1'b1, 4'd10};  {4'd5, 9'b00001}:     match = {1'b1, 4'd11};
                {4'd5, 9'b00000}:     match = {1'b1, 4'd12};
                default:              match = '0;
            endcase
            4'd5: case (key)
                {4'd4, 9'b0101}:      match = {1'b1, 4'd0};   {4'd4, 9'b0100}:      match = {1'b1, 4'd1};
                {4'd4, 9'b0011}:      match = {1'b1, 4'd2};   {4'd3, 9'b111}:       match = {1'b1, 4'd3};
                {4'd3, 9'b110}:       match = {1'b1, 4'd4};   {4'd3, 9'b101}:       match = {1'b1, 4'd5};
                {4'd3, 9'b100}:       match = {1'b1, 4'd6};   {4'd3, 9'b011}:       match = {1'b1, 4'd7};
                {4'd4, 9'b0010}:      match = {1'b1, 4'd8};   {4'd5, 9'b00001}:     match = {1'b1, 4'd9};
                {4'd4, 9'b0001}:      match = {1'b1, 4'd10};  {4'd5, 9'b00000}:     match = {1'b1, 4'd11};
                default:              match = '0;
            endcase
            4'd6: case (key)
                {4'd6, 9'b000001}:    match = {1'b1, 4'd0};   {4'd5, 9'b00001}:     match = {1'b1, 4'd1};
                {4'd3, 9'b111}:       match = {1'b1, 4'd2};   {4'd3, 9'b110}:       match = {1'b1, 4'd3};
                {4'd3, 9'b101}:       match = {1'b1, 4'd4};   {4'd3, 9'b100}:       match = {1'b1, 4'd5};
                {4'd3, 9'b011}:       match = {1'b1, 4'd6};   {4'd3, 9'b010}:       match = {1'b1, 4'd7};
                {4'd4, 9'b0001}:      match = {1'b1, 4'd8};   {4'd3, 9'b001}:       match = {1'b1, 4'd9};
                {4'd6, 9'b000000}:    match = {1'b1, 4'd10};
                default:              match = '0;
            endcase
            4'd7: case (key)
                {4'd6, 9'b000001}:    match = {1'b1, 4'd0};   {4'd5, 9'b00001}:     match = {1'b1, 4'd1};
                {4'd3, 9'b101}:       match = {1'b1, 4'd2};   {4'd3, 9'b100}:       match = {1'b1, 4'd3};
                {4'd3, 9'b011}:       match = {1'b1, 4'd4};   {4'd2, 9'b11}:        match = {1'b1, 4'd5};
                {4'd3, 9'b010}:       match = {1'b1, 4'd6};   {4'd4, 9'b0001}:      match = {1'b1, 4'd7};
                {4'd3, 9'b001}:       match = {1'b1, 4'd8};   {4'd6, 9'b000000}:    match = {1'b1, 4'd9};
                default:              match = '0;
            endcase
            4'd8: case (key)
                {4'd6, 9'b000001}:    match = {1'b1, 4'd0};   {4'd4, 9'b0001}:      match = {1'b1, 4'd1};
                {4'd5, 9'b00001}:     match = {1'b1, 4'd2};   {4'd3, 9'b011}:       match = {1'b1, 4'd3};
                {4'd2, 9'b11}:        match = {1'b1, 4'd4};   {4'd2, 9'b10}:        match = {1'b1, 4'd5};
                {4'd3, 9'b010}:       match = {1'b1, 4'd6};   {4'd3, 9'b001}:       match = {1'b1, 4'd7};
                {4'd6, 9'b000000}:    match = {1'b1, 4'd8};
                default:              match = '0;
            endcase
            4'd9: case (key)
                {4'd6, 9'b000001}:    match = {1'b1, 4'd0};   {4'd6, 9'b000000}:    match = {1'b1, 4'd1};
                {4'd4, 9'b0001}:      match = {1'b1, 4'd2};   {4'd2, 9'b11}:        match = {1'b1, 4'd3};
                {4'd2, 9'b10}:        match = {1'b1, 4'd4};   {4'd3, 9'b001}:       match = {1'b1, 4'd5};
                {4'd2, 9'b01}:        match = {1'b1, 4'd6};   {4'd5, 9'b00001}:     match = {1'b1, 4'd7};
                default:              match = '0;
            endcase
            4'd10: case (key)
                {4'd5, 9'b00001}:     match = {1'b1, 4'd0};   {4'd5, 9'b00000}:     match = {1'b1, 4'd1};
                {4'd3, 9'b001}:       match = {1'b1, 4'd2};   {4'd2, 9'b11}:        match = {1'b1, 4'd3};
                {4'd2, 9'b10}:        match = {1'b1, 4'd4};   {4'd2, 9'b01}:        match = {1'b1, 4'd5};
                {4'd4, 9'b0001}:      match = {1'b1, 4'd6};
                default:              match = '0;
            endcase
            4'd11: case (key)
                {4'd4, 9'b0000}:      match = {1'b1, 4'd0};   {4'd4, 9'b0001}:      match = {1'b1, 4'd1};
                {4'd3, 9'b001}:       match = {1'b1, 4'd2};   {4'd3, 9'b010}:       match = {1'b1, 4'd3};
                {4'd1, 9'b1}:         match = {1'b1, 4'd4};   {4'd3, 9'b011}:       match = {1'b1, 4'd5};
                default:              match = '0;
            endcase
            4'd12: case (key)
                {4'd4, 9'b0000}:      match = {1'b1, 4'd0};   {4'd4, 9'b0001}:      match = {1'b1, 4'd1};
                {4'd2, 9'b01}:        match = {1'b1, 4'd2};   {4'd1, 9'b1}:         match = {1'b1, 4'd3};
                {4'd3, 9'b001}:       match = {1'b1, 4'd4};
                default:              match = '0;
            endcase
            4'd13: case (key)
                {4'd3, 9'b000}:       match = {1'b1, 4'd0};   {4'd3, 9'b001}:       match = {1'b1, 4'd1};
                {4'd1, 9'b1}:         match = {1'b1, 4'd2};   {4'd2, 9'b01}:        match = {1'b1, 4'd3};
                default:              match = '0;
            endcase
            4'd14: case (key)
                {4'd2, 9'b00}:        match = {1'b1, 4'd0};   {4'd2, 9'b01}:        match = {1'b1, 4'd1};
                {4'd1, 9'b1}:         match = {1'b1, 4'd2};
                default:              match = '0;
            endcase
            4'd15: case (key)
                {4'd1, 9'b0}:         match = {1'b1, 4'd0};   {4'd1, 9'b1}:         match = {1'b1, 4'd1};
                default:              match = '0;
            endcase
            default: match = '0;
        endcase
    end

    // Control FSM plus code/count shifting and the held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tc_reg   <= '0;
            cnt      <= '0;
            code     <= '0;
            tz_value <= '0;
            tz_len   <= '0;
            tz_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (total_coeff == '0) begin
                            tz_value <= '0;
                            tz_len   <= '0;
                            tz_err   <= 1'b0;
                            state    <= DONE;
                        end else begin
                            tc_reg <= total_coeff;
                            code   <= '0;
                            cnt    <= '0;
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        code <= next_code;
                        cnt  <= next_len;
                        if (match[TZ_W]) begin
                            tz_value <= match[TZ_W-1:0];
                            tz_len   <= next_len;
                            tz_err   <= 1'b0;
                            state    <= DONE;
                        end else if (miss_end) begin
                            tz_value <= '0;
                            tz_len   <= next_len;
                            tz_err   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cavlc_total_zeros_decoder.sv
// Self-checking bench for the CAVLC total_zeros decoder: directed cases,
// reset/stall/back-to-back behaviour and every codeword of every row.
module tb_cavlc_total_zeros_decoder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] total_coeff;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       busy;
    logic       tz_valid;
    logic [3:0] tz_value;
    logic [3:0] tz_len;
    logic       tz_err;

    int checks   = 0;
    int failures = 0;

    // Expected results, packed as {err, value[3:0], len[3:0]}.
    logic [8:0] sb[$];
    logic [8:0] expEntry;
    logic       prevValid = 1'b0;

    cavlc_total_zeros_decoder #(.MAX_LEN(9), .TZ_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .total_coeff (total_coeff),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .busy        (busy),
        .tz_valid    (tz_valid),
        .tz_value    (tz_value),
        .tz_len      (tz_len),
        .tz_err      (tz_err)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Codewords of each TotalCoeff row, listed in total_zeros order 0,1,2,...
    function automatic string rowCodes(input int tc);
        case (tc)
            1:  return "1 011 010 0011 0010 00011 00010 000011 000010 0000011 0000010 00000011 00000010 000000011 000000010 000000001";
            2:  return "111 110 101 100 011 0101 0100 0011 0010 00011 00010 000011 000010 000001 000000";
            3:  return "0101 111 110 101 0100 0011 100 011 0010 00011 00010 000001 00001 000000";
            4:  return "00011 111 0101 0100 110 101 100 0011 011 0010 00010 00001 00000";
            5:  return "0101 0100 0011 111 110 101 100 011 0010 00001 0001 00000";
            6:  return "000001 00001 111 110 101 100 011 010 0001 001 000000";
            7:  return "000001 00001 101 100 011 11 010 0001 001 000000";
            8:  return "000001 0001 00001 011 11 10 010 001 000000";
            9:  return "000001 000000 0001 11 10 001 01 00001";
            10: return "00001 00000 001 11 10 01 0001";
            11: return "0000 0001 001 010 1 011";
            12: return "0000 0001 01 1 001";
            13: return "000 001 1 01";
            14: return "00 01 1";
            15: return "0 1";
            default: return "";
        endcase
    endfunction

    // Output monitor: every strobe must be single-cycle and match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && tz_valid) begin
            checkOutput("strobeWidth", int'(prevValid), 0);
            checkOutput("sbPending", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                expEntry = sb.pop_front();
                checkOutput("tzErr",   int'(tz_err),   int'(expEntry[8]));
                checkOutput("tzValue", int'(tz_value), int'(expEntry[7:4]));
                checkOutput("tzLen",   int'(tz_len),   int'(expEntry[3:0]));
            end
        end
        prevValid <= tz_valid;
    end

    // Runs one decode: start pulse, nbits MSB-first bits with 'gap' idle cycles
    // before each one (with a stray start that must be ignored), then checks the
    // strobe latency. Leaves time at the strobe cycle so the next start is back-to-back.
    task automatic applyStimulus(input logic [3:0] tc, input logic [8:0] bits, input int nbits,
                                 input int gap, input logic [3:0] expVal, input logic [3:0] expLen,
                                 input logic expErr);
        sb.push_back({expErr, expVal, expLen});
        @(negedge clk);
        start       = 1'b1;
        total_coeff = tc;
        @(negedge clk);
        start       = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            for (int g = 0; g < gap; g++) begin
                bit_valid   = 1'b0;
                bit_in      = 1'b1;
                start       = (g == 0);
                total_coeff = (g == 0) ? 4'd15 : tc;
                @(negedge clk);
                start = 1'b0;
                checkOutput("stallBusy",  int'(busy),      1);
                checkOutput("stallReady", int'(bit_ready), 1);
            end
            bit_in    = bits[nbits-1-i];
            bit_valid = 1'b1;
            checkOutput("ready", int'(bit_ready), 1);
            @(negedge clk);
            bit_valid = 1'b0;
            if (i < nbits - 1)
                checkOutput("early", int'(tz_valid), 0);
        end
        checkOutput("latency",   int'(tz_valid),  1);
        checkOutput("readyDone", int'(bit_ready), 0);
    endtask

    // Main sequence: reset, directed cases, mid-decode reset, then the full tables.
    initial begin
        string s;
        int    tz;
        int    n;
        logic [8:0] pat;

        rst = 1'b1; start = 1'b0; total_coeff = 4'd0; bit_in = 1'b0; bit_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstBusy",  int'(busy),      0);
        checkOutput("rstReady", int'(bit_ready), 0);
        checkOutput("rstValid", int'(tz_valid),  0);
        checkOutput("rstValue", int'(tz_value),  0);
        checkOutput("rstLen",   int'(tz_len),    0);
        checkOutput("rstErr",   int'(tz_err),    0);
        rst = 1'b0;

        $display("[TB] directed cases");
        applyStimulus(4'd1,  9'b011,       3, 0, 4'd1, 4'd3, 1'b0);
        applyStimulus(4'd7,  9'b11,        2, 0, 4'd5, 4'd2, 1'b0);
        applyStimulus(4'd15, 9'b1,         1, 0, 4'd1, 4'd1, 1'b0);
        applyStimulus(4'd15, 9'b0,         1, 0, 4'd0, 4'd1, 1'b0);
        applyStimulus(4'd1,  9'b000000000, 9, 0, 4'd0, 4'd9, 1'b1);
        applyStimulus(4'd3,  9'b0101,      4, 3, 4'd0, 4'd4, 1'b0);
        applyStimulus(4'd1,  9'b000000001, 9, 0, 4'd15, 4'd9, 1'b0);

        $display("[TB] reset during decode");
        @(negedge clk);
        start = 1'b1; total_coeff = 4'd1;
        @(negedge clk);
        start = 1'b0; bit_valid = 1'b1; bit_in = 1'b0;
        repeat (2) @(negedge clk);
        bit_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstBusy",  int'(busy),      0);
        checkOutput("midRstReady", int'(bit_ready), 0);
        checkOutput("midRstValid", int'(tz_valid),  0);
        checkOutput("midRstValue", int'(tz_value),  0);
        checkOutput("midRstLen",   int'(tz_len),    0);
        checkOutput("midRstErr",   int'(tz_err),    0);
        @(negedge clk);
        checkOutput("midRstNoStrobe", int'(tz_valid), 0);
        applyStimulus(4'd0, 9'b0, 0, 0, 4'd0, 4'd0, 1'b0);

        $display("[TB] full code tables");
        for (int tc = 1; tc <= 15; tc++) begin
            s   = rowCodes(tc);
            tz  = 0;
            n   = 0;
            pat = '0;
            for (int i = 0; i <= s.len(); i++) begin
                if (i == s.len() || s[i] == " ") begin
                    if (n > 0) begin
                        applyStimulus(4'(tc), pat, n, 0, 4'(tz), 4'(n), 1'b0);
                        tz++;
                        n   = 0;
                        pat = '0;
                    end
                end else begin
                    pat = {pat[7:0], (s[i] == "1")};
                    n++;
                end
            end
            checkOutput("rowCount", tz, 17 - tc);
        end

        repeat (3) @(negedge clk);
        checkOutput("sbDrained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
